// File: rtl/dsp_mac_pkg.sv
// Shared types and post-processing helpers for the streaming multi-lane MAC.
// Helpers take a MAXW-wide container plus the real field widths, so any parameter set up to MAXW fits.
package dsp_mac_pkg;

   localparam int MAXW  = 128;
   localparam int LEN_W = 32;

   typedef enum logic {SIGNED, UNSIGNED} mode_t;

   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [5:0]       shift;
      logic             rnd;
      logic             sat;
   } frame_cfg_t;

   typedef struct packed {
      logic [5:0] shift;
      logic       rnd;
      logic       sat;
      mode_t      mode;
   } post_cfg_t;

   typedef struct packed {
      logic             flag;
      logic [MAXW-1:0]  val;
   } sat_res_t;

   // v holds an nacc-bit accumulator in its low bits; the result is the nacc-bit shifted value.
   function automatic logic [MAXW-1:0] round_shift(input logic [MAXW-1:0] v,
                                                   input int nacc, input int sh,
                                                   input logic rnd, input logic uns);
      logic [MAXW-1:0]        mask;
      logic [MAXW-1:0]        r;
      logic signed [MAXW-1:0] sx;
      logic                   neg;
      int                     s;
      s    = (sh >= nacc) ? nacc - 1 : sh;
      mask = (MAXW'(1) << nacc) - MAXW'(1);
      r    = v & mask;
      if (rnd && s != 0)
         r = (r + (MAXW'(1) << (s - 1))) & mask;
      if (uns) begin
         r = r >> s;
      end else begin
         neg = |(r & (MAXW'(1) << (nacc - 1)));
         sx  = neg ? (r | ~mask) : r;
         r   = (sx >>> s) & mask;
      end
      return r;
   endfunction

   function automatic sat_res_t saturate(input logic [MAXW-1:0] r,
                                         input int nacc, input int nz,
                                         input logic sat_en, input logic uns);
      sat_res_t               res;
      logic [MAXW-1:0]        amask;
      logic [MAXW-1:0]        zmask;
      logic [MAXW-1:0]        lim;
      logic signed [MAXW-1:0] sx;
      logic signed [MAXW-1:0] pmax;
      logic signed [MAXW-1:0] nmin;
      logic                   neg;
      amask = (MAXW'(1) << nacc) - MAXW'(1);
      zmask = (MAXW'(1) << nz) - MAXW'(1);
      lim   = MAXW'(1) << (nz - 1);
      neg   = |(r & (MAXW'(1) << (nacc - 1)));
      sx    = neg ? (r | ~amask) : r;
      pmax  = lim - MAXW'(1);
      nmin  = -lim;
      res.flag = 1'b0;
      res.val  = r & zmask;
      if (sat_en) begin
         if (uns) begin
            if (neg) begin
               res.val  = '0;
               res.flag = 1'b1;
            end else if (r > zmask) begin
               res.val  = zmask;
               res.flag = 1'b1;
            end
         end else begin
            if (sx > pmax) begin
               res.val  = pmax & zmask;
               res.flag = 1'b1;
            end else if (sx < nmin) begin
               res.val  = nmin & zmask;
               res.flag = 1'b1;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dsp_mac_stream_if.sv
// Streaming operand/result bundle for dsp_mac_stream; slave is the engine side.
interface dsp_mac_stream_if #(
   parameter int NBITS_A = 20,
   parameter int NBITS_B = 18,
   parameter int NLANES  = 2,
   parameter int NBITS_Z = 38,
   parameter int CNT_W   = 16
);
   logic                        clear_i;
   logic                        in_valid_i;
   logic                        in_ready_o;
   logic [NLANES*NBITS_A-1:0]   a_i;
   logic [NLANES*NBITS_B-1:0]   b_i;
   logic                        unsigned_a_i;
   logic                        unsigned_b_i;
   logic                        subtract_i;
   logic [CNT_W-1:0]            acc_len_i;
   logic [5:0]                  shift_right_i;
   logic                        round_i;
   logic                        saturate_enable_i;
   logic                        out_valid_o;
   logic                        out_ready_i;
   logic [NBITS_Z-1:0]          z_o;
   logic                        sat_flag_o;

   modport master (
      output clear_i, in_valid_i, a_i, b_i, unsigned_a_i, unsigned_b_i, subtract_i,
             acc_len_i, shift_right_i, round_i, saturate_enable_i, out_ready_i,
      input  in_ready_o, out_valid_o, z_o, sat_flag_o
   );

   modport slave (
      input  clear_i, in_valid_i, a_i, b_i, unsigned_a_i, unsigned_b_i, subtract_i,
             acc_len_i, shift_right_i, round_i, saturate_enable_i, out_ready_i,
      output in_ready_o, out_valid_o, z_o, sat_flag_o
   );
endinterface

// File: rtl/bw_multiplier.sv
// Single-lane multiplier with independent signed/unsigned operand modes; exact product.
module bw_multiplier #(
   parameter int NBITS_A = 20,
   parameter int NBITS_B = 18
)(
   input  logic [NBITS_A-1:0]              a,
   input  logic [NBITS_B-1:0]              b,
   input  logic                            unsigned_a,
   input  logic                            unsigned_b,
   output logic signed [NBITS_A+NBITS_B:0] p
);
   localparam int PW = NBITS_A + NBITS_B + 1;

   logic signed [NBITS_A:0] a_x;
   logic signed [NBITS_B:0] b_x;

   // One guard bit lets signed and unsigned operands share a signed multiply.
   assign a_x = {~unsigned_a & a[NBITS_A-1], a};
   assign b_x = {~unsigned_b & b[NBITS_B-1], b};
   assign p   = PW'(a_x) * PW'(b_x);
endmodule

// File: rtl/dsp_mac_stream.sv
// Pipelined multi-lane MAC: operand register, lane product sum, frame accumulator,
// then rounded/shifted/saturated result held on a back-pressured output register.
module dsp_mac_stream
   import dsp_mac_pkg::*;
#(
   parameter int NBITS_A   = 20,
   parameter int NBITS_B   = 18,
   parameter int NLANES    = 2,
   parameter int NBITS_ACC = 64,
   parameter int NBITS_Z   = 38,
   parameter int CNT_W     = 16
)(
   input  logic            clock_i,
   input  logic            s_reset_n,
   dsp_mac_stream_if.slave bus
);
   localparam int PW = NBITS_A + NBITS_B + 1;

   logic en;
   logic accept;
   logic flush;
   logic out_valid_q;
   logic [NBITS_Z-1:0] z_q;
   logic sat_q;

   assign flush          = ~s_reset_n | bus.clear_i;
   assign en             = ~(out_valid_q & ~bus.out_ready_i);
   assign bus.in_ready_o = en & s_reset_n;
   assign accept         = bus.in_valid_i & bus.in_ready_o & ~bus.clear_i;
   assign bus.out_valid_o = out_valid_q;
   assign bus.z_o         = z_q;
   assign bus.sat_flag_o  = sat_q;

   // Frame position is tracked at the input so configuration is latched with the first beat.
   logic [CNT_W-1:0] beat_cnt;
   frame_cfg_t       cfg_cur;
   frame_cfg_t       cfg_beat;
   post_cfg_t        post_beat;
   logic             first_beat;
   logic             last_beat;
   logic [LEN_W-1:0] len_eff;

   always_comb begin
      first_beat = (beat_cnt == '0);
      cfg_beat   = cfg_cur;
      if (first_beat) begin
         cfg_beat.len   = LEN_W'(bus.acc_len_i);
         cfg_beat.shift = bus.shift_right_i;
         cfg_beat.rnd   = bus.round_i;
         cfg_beat.sat   = bus.saturate_enable_i;
      end
      len_eff        = (cfg_beat.len == '0) ? LEN_W'(1) : cfg_beat.len;
      last_beat      = (LEN_W'(beat_cnt) == len_eff - LEN_W'(1));
      post_beat.shift = cfg_beat.shift;
      post_beat.rnd   = cfg_beat.rnd;
      post_beat.sat   = cfg_beat.sat;
      post_beat.mode  = (bus.unsigned_a_i & bus.unsigned_b_i) ? UNSIGNED : SIGNED;
   end

   logic                       v1;
   logic [NLANES*NBITS_A-1:0]  a1;
   logic [NLANES*NBITS_B-1:0]  b1;
   logic                       ua1;
   logic                       ub1;
   logic                       sub1;
   logic                       first1;
   logic                       last1;
   post_cfg_t                  post1;

   logic                       v2;
   logic [NBITS_ACC-1:0]       sum2;
   logic                       sub2;
   logic                       first2;
   logic                       last2;
   post_cfg_t                  post2;

   logic [NBITS_ACC-1:0]       acc;
   logic                       done3;
   post_cfg_t                  post3;

   logic signed [PW-1:0]       prod [NLANES];
   logic [NBITS_ACC-1:0]       sum_c;
   logic [NBITS_ACC-1:0]       term;
   logic [NBITS_ACC-1:0]       acc_next;

   for (genvar l = 0; l < NLANES; l++) begin : g_lane
      bw_multiplier #(
         .NBITS_A (NBITS_A),
         .NBITS_B (NBITS_B)
      ) u_mul (
         .a          (a1[l*NBITS_A +: NBITS_A]),
         .b          (b1[l*NBITS_B +: NBITS_B]),
         .unsigned_a (ua1),
         .unsigned_b (ub1),
         .p          (prod[l])
      );
   end

   always_comb begin
      sum_c = '0;
      for (int l = 0; l < NLANES; l++)
         sum_c = sum_c + NBITS_ACC'(prod[l]);
   end

   always_comb begin
      term     = sub2 ? (~sum2 + NBITS_ACC'(1)) : sum2;
      acc_next = first2 ? term : acc + term;
   end

   logic [MAXW-1:0] shifted;
   sat_res_t        sres;

   always_comb begin
      shifted = round_shift(MAXW'(acc), NBITS_ACC, int'(post3.shift), post3.rnd,
                            post3.mode == UNSIGNED);
      sres    = saturate(shifted, NBITS_ACC, NBITS_Z, post3.sat, post3.mode == UNSIGNED);
   end

   always_ff @(posedge clock_i) begin
      if (flush) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         done3       <= 1'b0;
         acc         <= '0;
         beat_cnt    <= '0;
         out_valid_q <= 1'b0;
         z_q         <= '0;
         sat_q       <= 1'b0;
      end else begin
         if (accept)
            beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
         if (en) begin
            v1    <= accept;
            v2    <= v1;
            done3 <= v2 & last2;
            if (v2)
               acc <= acc_next;
            // A new result replaces the old one only on the edge that consumes it.
            out_valid_q <= done3;
            if (done3) begin
               z_q   <= NBITS_Z'(sres.val);
               sat_q <= sres.flag;
            end
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (en) begin
         if (accept) begin
            a1      <= bus.a_i;
            b1      <= bus.b_i;
            ua1     <= bus.unsigned_a_i;
            ub1     <= bus.unsigned_b_i;
            sub1    <= bus.subtract_i;
            first1  <= first_beat;
            last1   <= last_beat;
            post1   <= post_beat;
            cfg_cur <= cfg_beat;
         end
         if (v1) begin
            sum2   <= sum_c;
            sub2   <= sub1;
            first2 <= first1;
            last2  <= last1;
            post2  <= post1;
         end
         if (v2 & last2)
            post3 <= post2;
      end
   end

endmodule

// File: doc/dsp_mac_stream.md
Name: dsp_mac_stream

Overview:
Parametrised, pipelined multi-lane multiply-accumulate engine. It is the streaming successor to the single-lane type-1 DSP MAC.
- Each accepted beat carries NLANES A×B operand pairs. Their products are summed, then accumulated over a programmable frame length.
- At frame end, the accumulator is rounded, shifted and saturated. The result is presented on a valid/ready output port with full back-pressure.
- Sits between fabric streaming logic and the output bus.

Parameters:
NBITS_A, 20, per-lane A operand width
NBITS_B, 18, per-lane B operand width
NLANES, 2, multiplier lanes summed per beat (1..8)
NBITS_ACC, 64, accumulator width (≥ NBITS_A+NBITS_B+clog2(NLANES)+1)
NBITS_Z, 38, result width
CNT_W, 16, frame-length counter width

Ports:
clock_i  in  1  clock; all logic rising-edge
s_reset_n  in  1  reset; synchronous, active-low
clear_i  in  1  synchronous pipeline/accumulator flush
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when in_valid_i&in_ready_o
a_i  in  NLANES*NBITS_A  packed A operands, lane 0 in LSBs
b_i  in  NLANES*NBITS_B  packed B operands, lane 0 in LSBs
unsigned_a_i  in  1  A unsigned (per beat)
unsigned_b_i  in  1  B unsigned (per beat)
subtract_i  in  1  subtract this beat's product sum (per beat)
acc_len_i  in  CNT_W  beats per frame; 0 treated as 1
shift_right_i  in  6  result right shift
round_i  in  1  round-half-up before shift
saturate_enable_i  in  1  clamp to NBITS_Z range
out_valid_o  out  1  result valid
out_ready_i  in  1  result accepted
z_o  out  NBITS_Z  result
sat_flag_o  out  1  result was clamped

Behaviour:
- Reset (s_reset_n=0 at edge): all pipeline valids 0, accumulator 0, beat counter 0, out_valid_o=0, z_o=0, sat_flag_o=0. in_ready_o=0 while s_reset_n=0.
- Stall enable: en = ~(out_valid_o & ~out_ready_i). Every stage advances only when en=1.
- in_ready_o = en & s_reset_n. This is a combinational path from out_ready_i, which is permitted.
- Stage S1: on accept, register operands plus per-beat flags.
- Stage S2: per lane, signed/unsigned product. Each product is sign-extended, or zero-extended when both flags are unsigned, to NBITS_ACC, then all lanes are summed.
- Stage S3 (accumulate):
  - First beat of frame: acc = ±sum.
  - Other beats: acc = acc ± sum.
  - Arithmetic wraps modulo 2^NBITS_ACC.
- Frame control:
  - Beat counter increments per S3 beat.
  - Frame configuration (acc_len_i, shift_right_i, round_i, saturate_enable_i) is captured when the first beat of a frame is accepted.
  - Changes to those inputs mid-frame have no effect until the next frame.
- Frame end (counter = len-1): counter returns to 0 and the post-processed result loads the output register. out_valid_o rises on the next edge.
- Latency: last beat accepted at edge t → out_valid_o=1 after edge t+3.
- Post-processing:
  - Round: if round and shift≠0, add 1<<(shift-1).
  - Shift: arithmetic shift (logical when unsigned mode). A shift ≥ NBITS_ACC is clamped to NBITS_ACC-1.
  - Saturate, signed mode: clamp to [-2^(Z-1), 2^(Z-1)-1].
  - Saturate, unsigned mode: negative → 0; > 2^Z-1 → 2^Z-1.
  - sat_flag_o=1 iff clamping altered the value. With saturation disabled, z_o is the truncated low NBITS_Z bits and sat_flag_o=0.
- Output hold: z_o and sat_flag_o stay stable while out_valid_o & ~out_ready_i. A new result loads on the same edge that the old one is accepted.
- clear_i=1: next edge behaves like reset except in_ready_o. Beats in flight are dropped. clear_i has priority over an accept in the same cycle.
- No beat is ever lost or duplicated under arbitrary in_valid_i/out_ready_i patterns.

Decomposition:
- Package dsp_mac_pkg:
  - frame-config struct (len, shift, round, sat)
  - mode enum (SIGNED, UNSIGNED)
  - pure functions for round/shift and saturate
- Sub-module: existing bw_multiplier, instanced once per lane via generate.

Test Plan:
- NLANES=2, signed, a=(3,-2), b=(5,4), acc_len=1, shift=0 → z_o=7 three edges after accept, sat_flag_o=0.
- Same beat repeated 4×, acc_len=4 → single result z_o=28. With subtract_i on beat 2 → z_o=14.
- Frame sum 7, shift=1: round_i=1 → z_o=4; round_i=0 → z_o=3.
- Signed, both lanes a=-2^19, b=-2^17, saturation on → z_o=0x1F_FFFF_FFFF, sat_flag_o=1. Saturation off → z_o=0x20_0000_0000.
- Unsigned both, a=1, b=1, subtract_i=1, saturation on → z_o=0, sat_flag_o=1.
- Hold out_ready_i=0 for 5 cycles with in_valid_i=1 → z_o stable, in_ready_o=0, every frame result later delivered in order. Assert clear_i mid-frame → out_valid_o=0 next cycle and the next frame restarts from acc=0.
